// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer port bundle for vga_fb_arbiter: the writer handshake plus the
// single RAM port the arbiter owns.
//
// Writer handshake: a write transfers on every cycle where wr_valid and
// wr_ready are both high. Once wr_valid is raised, wr_addr and wr_data stay
// stable until that transfer cycle. wr_ready is combinational, never high
// while wr_valid is low, and the writer must not wait for it before raising
// wr_valid.
//
// The slave modport is the arbiter. The master modport is the environment,
// which drives the writer request and owns the RAM.
interface vga_fb_arbiter_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 17
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the single framebuffer RAM port between the display
// prefetch FIFO (scan-out) and a valid/ready pixel writer. Fetch wins whenever
// the FIFO occupancy drops below LOW_WATER or the writer is idle.
// Optional build macro VGA_ARB_STATS_EN adds saturating wr_stall_cnt / uf_cnt.
module vga_fb_arbiter #(
  parameter int DATA_W     = 12,
  parameter int ADDR_W     = 17,
  parameter int FB_WORDS   = 76800,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              underflow,
`ifdef VGA_ARB_STATS_EN
  output logic [15:0]       wr_stall_cnt,
  output logic [15:0]       uf_cnt,
`endif
  vga_fb_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_C = (PTR_W+2)'(FIFO_DEPTH);
  localparam logic [PTR_W+1:0] LOW_C   = (PTR_W+2)'(LOW_WATER);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [PTR_W:0]    level;
  logic [PTR_W+1:0]  occ;
  logic              inflight;
  logic [ADDR_W-1:0] fetch_addr;
  logic              grant_fetch;
  logic              grant_write;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              empty_rd;

  // Occupancy counts the read already issued so the FIFO can never overfill.
  assign level      = wr_ptr - rd_ptr;
  assign occ        = {1'b0, level} + {{(PTR_W+1){1'b0}}, inflight};
  assign fifo_empty = (level == '0);

  // Read data from a fetch lands one cycle later; frame_start drops it.
  assign push     = inflight && !frame_start;
  assign pop      = pix_rd && !frame_start && !fifo_empty;
  assign empty_rd = pix_rd && !frame_start && fifo_empty;

  // Per-cycle arbitration: fetch below low water or when the writer is idle.
  always_comb begin
    grant_fetch = 1'b0;
    grant_write = 1'b0;
    if (!reset && !frame_start) begin
      if ((occ < DEPTH_C) && ((occ < LOW_C) || !bus.wr_valid)) begin
        grant_fetch = 1'b1;
      end else if (bus.wr_valid) begin
        grant_write = 1'b1;
      end
    end
  end

  // RAM port and writer ready follow the grant combinationally.
  always_comb begin
    bus.mem_en    = grant_fetch || grant_write;
    bus.mem_we    = grant_write;
    bus.wr_ready  = grant_write;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (grant_write) begin
      bus.mem_addr  = bus.wr_addr;
      bus.mem_wdata = bus.wr_data;
    end else if (grant_fetch) begin
      bus.mem_addr = fetch_addr;
    end
  end

  // FIFO pointers, in-flight flag and wrapping fetch address.
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight   <= 1'b0;
      fetch_addr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      inflight <= grant_fetch;
      if (grant_fetch) begin
        fetch_addr <= (fetch_addr == LAST_ADDR) ? '0 : fetch_addr + 1'b1;
      end
    end
  end

  // FIFO storage; never written while full because occ bounds the fetches.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= bus.mem_rdata;
    end
  end

  // Registered pixel output and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_data  <= '0;
      underflow <= 1'b0;
    end else begin
      if (pop) begin
        pix_data <= fifo_mem[rd_ptr[PTR_W-1:0]];
      end else if (pix_rd) begin
        pix_data <= '0;
      end
      if (empty_rd) underflow <= 1'b1;
    end
  end

`ifdef VGA_ARB_STATS_EN
  // Saturating statistics; uf_cnt restarts every frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_stall_cnt <= '0;
      uf_cnt       <= '0;
    end else begin
      if (bus.wr_valid && !grant_write && (wr_stall_cnt != 16'hFFFF)) begin
        wr_stall_cnt <= wr_stall_cnt + 16'd1;
      end
      if (frame_start) begin
        uf_cnt <= '0;
      end else if (empty_rd && (uf_cnt != 16'hFFFF)) begin
        uf_cnt <= uf_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: synchronous RAM model, queue-based reference of
// the pixel stream and arbitration rules, directed phases plus random traffic.
module tb_vga_fb_arbiter;
  localparam int DATA_W     = 12;
  localparam int ADDR_W     = 17;
  localparam int FB_WORDS   = 300;
  localparam int FIFO_DEPTH = 16;
  localparam int LOW_WATER  = 4;
  localparam int RAM_WORDS  = 512;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic frame_start;
  logic pix_rd;
  logic [DATA_W-1:0] pix_data;
  logic underflow;
`ifdef VGA_ARB_STATS_EN
  logic [15:0] wr_stall_cnt;
  logic [15:0] uf_cnt;
`endif

  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  vga_fb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FB_WORDS(FB_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH), .LOW_WATER(LOW_WATER)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_start(frame_start),
    .pix_rd(pix_rd),
    .pix_data(pix_data),
    .underflow(underflow),
`ifdef VGA_ARB_STATS_EN
    .wr_stall_cnt(wr_stall_cnt),
    .uf_cnt(uf_cnt),
`endif
    .bus(bus)
  );

  // Synchronous single-port RAM, preloaded with data = address[11:0].
  logic [DATA_W-1:0] ram [RAM_WORDS];
  initial for (int i = 0; i < RAM_WORDS; i++) ram[i] <= DATA_W'(i);
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[8:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr[8:0]];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] ram_ref [RAM_WORDS];
  bit                m_inflight;
  logic [DATA_W-1:0] m_inflight_data;
  int                m_fetch_addr;
  logic [DATA_W-1:0] m_pix;
  bit                m_uf;
  int                m_stall;
  int                m_ufc;
  int                n_cmp;
  int                n_bad;
  bit                auto_wr;
  logic              last_en, last_we, last_ready;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] wd [10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_inflight   = 0;
    m_fetch_addr = 0;
    m_pix        = '0;
    m_uf         = 0;
    m_stall      = 0;
    m_ufc        = 0;
  endtask

  task automatic new_wr();
    bus.wr_addr = ADDR_W'($urandom_range(0, FB_WORDS - 1));
    bus.wr_data = DATA_W'($urandom);
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model
  // as the coming edge will, then step past the edge.
  task automatic tick();
    int occ;
    bit gf, gw;
    @(negedge clk);
    occ = exp_q.size() + (m_inflight ? 1 : 0);
    gf = 0;
    gw = 0;
    if (!reset && !frame_start) begin
      if (occ < FIFO_DEPTH && (occ < LOW_WATER || !bus.wr_valid)) gf = 1;
      else if (bus.wr_valid) gw = 1;
    end
    last_en    = bus.mem_en;
    last_we    = bus.mem_we;
    last_ready = bus.wr_ready;
    last_addr  = bus.mem_addr;
    chk("mem_en", bus.mem_en, gf | gw);
    chk("mem_we", bus.mem_we, gw);
    chk("wr_ready", bus.wr_ready, gw);
    if (gf) chk("fetch_addr", bus.mem_addr, m_fetch_addr);
    if (gw) begin
      chk("wr_addr_pass", bus.mem_addr, bus.wr_addr);
      chk("wr_data_pass", bus.mem_wdata, bus.wr_data);
    end
    chk("pix_data", pix_data, m_pix);
    chk("underflow", underflow, m_uf);
`ifdef VGA_ARB_STATS_EN
    chk("wr_stall_cnt", wr_stall_cnt, m_stall);
    chk("uf_cnt", uf_cnt, m_ufc);
`endif
    if (reset) begin
      model_reset();
    end else begin
      if (pix_rd) begin
        if (frame_start) m_pix = '0;
        else if (exp_q.size() > 0) m_pix = exp_q.pop_front();
        else begin
          m_pix = '0;
          m_uf  = 1;
          if (m_ufc < 16'hFFFF) m_ufc++;
        end
      end
      if (bus.wr_valid && !gw && m_stall < 16'hFFFF) m_stall++;
      if (frame_start) begin
        exp_q.delete();
        m_inflight   = 0;
        m_fetch_addr = 0;
        m_ufc        = 0;
      end else begin
        if (m_inflight) exp_q.push_back(m_inflight_data);
        m_inflight = gf;
        if (gf) begin
          m_inflight_data = ram_ref[m_fetch_addr];
          m_fetch_addr    = (m_fetch_addr + 1) % FB_WORDS;
        end
        if (gw) ram_ref[int'(bus.wr_addr[8:0])] = bus.wr_data;
      end
    end
    @(posedge clk);
    #1;
    if (auto_wr && gw) new_wr();
  endtask

  // Holds the pending write until it is acknowledged (bounded).
  task automatic finish_write();
    bit acked;
    acked = !bus.wr_valid;
    for (int i = 0; i < 40 && !acked; i++) begin
      tick();
      if (last_ready) begin
        acked = 1;
        bus.wr_valid = 1'b0;
      end
    end
    chk("wr_eventually_ack", acked, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit found;
    n_cmp = 0;
    n_bad = 0;
    auto_wr = 0;
    for (int i = 0; i < RAM_WORDS; i++) ram_ref[i] = DATA_W'(i);
    model_reset();
    reset = 1'b1;
    frame_start = 1'b0;
    pix_rd = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_addr = ADDR_W'(5);
    bus.wr_data = 12'hABC;
    @(posedge clk);
    #1;

    // Reset with a pending write: nothing granted, nothing acknowledged.
    repeat (3) tick();
    reset = 1'b0;
    bus.wr_valid = 1'b0;

    // Idle fill: fetches 0..15 back to back, then the port goes quiet.
    repeat (20) tick();
    chk("idle_full_no_fetch", bus.mem_en, 1'b0);

    // 20 pops, one every 2 cycles: pixels follow the address pattern.
    for (int k = 0; k < 20; k++) begin
      pix_rd = 1'b1;
      tick();
      pix_rd = 1'b0;
      chk("pix_seq", pix_data, k);
      tick();
    end
    chk("uf_after_seq", underflow, 1'b0);

    // FIFO full: 10 writes to 0x100..0x109 all accepted on consecutive cycles.
    repeat (10) tick();
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wd[i] = DATA_W'($urandom);
      bus.wr_addr = ADDR_W'(256 + i);
      bus.wr_data = wd[i];
      tick();
      chk("full_wr_ready", last_ready, 1'b1);
      chk("full_wr_is_write", last_we, 1'b1);
    end
    bus.wr_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) chk("ram_written", ram[256 + i], wd[i]);

    // Continuous writer and continuous pops: display never starves.
    auto_wr = 1;
    new_wr();
    bus.wr_valid = 1'b1;
    pix_rd = 1'b1;
    repeat (150) tick();
    chk("uf_after_stream", underflow, 1'b0);
    auto_wr = 0;
    pix_rd = 1'b0;
    finish_write();

    // Random pops and writes.
    for (int i = 0; i < 300; i++) begin
      pix_rd = ($urandom_range(0, 3) != 0);
      if (!bus.wr_valid && $urandom_range(0, 1) == 1) begin
        new_wr();
        bus.wr_valid = 1'b1;
      end
      tick();
      if (last_ready) bus.wr_valid = 1'b0;
    end
    pix_rd = 1'b0;
    finish_write();
    chk("uf_after_random", underflow, 1'b0);

    // Draining across the end of the frame: fetch address wraps to 0.
    pix_rd = 1'b1;
    found = 0;
    for (int i = 0; i < FB_WORDS + 50 && !found; i++) begin
      tick();
      if (last_en && !last_we && last_addr == ADDR_W'(FB_WORDS - 1)) found = 1;
    end
    chk("wrap_last_seen", found, 1'b1);
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      tick();
      if (last_en && !last_we) found = 1;
    end
    chk("wrap_next_seen", found, 1'b1);
    chk("wrap_addr", last_addr, 0);

    // frame_start mid-line with a pop and an in-flight read.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pix_rd = 1'b0;
    chk("fs_no_grant", last_en, 1'b0);
    chk("fs_pix_zero", pix_data, 0);
    chk("fs_no_uf", underflow, 1'b0);
    tick();
    chk("fs_refetch", last_en && !last_we, 1'b1);
    chk("fs_refetch_addr", last_addr, 0);
    repeat (2) tick();
    pix_rd = 1'b1;
    tick();
    pix_rd = 1'b0;
    chk("fs_first_pix", pix_data, ram_ref[0]);

    // Pop before the first push after reset: sticky underflow.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    pix_rd = 1'b1;
    tick();
    pix_rd = 1'b0;
    chk("uf_pix_zero", pix_data, 0);
    chk("uf_set", underflow, 1'b1);
`ifdef VGA_ARB_STATS_EN
    chk("uf_cnt_one", uf_cnt, 1);
`endif
    repeat (3) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    chk("uf_sticky", underflow, 1'b1);
`ifdef VGA_ARB_STATS_EN
    chk("uf_cnt_cleared", uf_cnt, 0);
`endif
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
